// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM state encodings, frame constants
// and the oversampling tick divisor helper.
package uart_pkg;

    localparam int OVERSAMPLE = 16;
    localparam int DATA_BITS  = 8;

    typedef logic [2:0] uart_state_t;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_START     = 3'd1;
    localparam logic [2:0] ST_DATA      = 3'd2;
    localparam logic [2:0] ST_PARITY    = 3'd3;
    localparam logic [2:0] ST_STOP      = 3'd4;
    localparam logic [2:0] ST_WAIT_IDLE = 3'd5;

    // Rounded clk/(baud*OVERSAMPLE).
    function automatic int uart_div(input int clk_hz, input int baud);
        return (clk_hz + baud * (OVERSAMPLE / 2)) / (baud * OVERSAMPLE);
    endfunction

endpackage

// File: rtl/uart_rx_sync_fifo.sv
// First-word-fall-through receive FIFO; head is registered and holds its last value when empty.
module uart_rx_sync_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = DATA_BITS
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH+1)-1:0] level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    rd_next;
    logic [LW-1:0]    count;
    logic [LW-1:0]    count_next;
    logic             push_ok;
    logic             pop_ok;

    assign empty   = (count == '0);
    assign full    = (count == LW'(DEPTH));
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign level   = count;

    always_comb begin
        rd_next    = rd_ptr;
        count_next = count;
        if (pop_ok) begin
            rd_next = rd_ptr + AW'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_next = count + LW'(1);
            2'b01:   count_next = count - LW'(1);
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Head register tracks the entry at the next read pointer, bypassing a write into an empty slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            head   <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            rd_ptr <= rd_next;
            count  <= count_next;
            if (count_next != '0) begin
                head <= (push_ok && (wr_ptr == rd_next)) ? push_data : mem[rd_next];
            end
        end
    end

endmodule

// File: rtl/uart_rx_fifo_ctrl.sv
// UART receiver: rx synchroniser, 16x oversampling frame recovery and FWFT byte FIFO.
// Optional parity checking is enabled by defining UART_RX_PARITY_EN.
module uart_rx_fifo_ctrl
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int BAUD       = 115_200,
    parameter int FIFO_DEPTH = 8,
    parameter int PARITY_ODD = 0
) (
    input  logic                            i_clk_50mhz,
    input  logic                            i_reset_n,
    input  logic                            i_rx,
    output logic [7:0]                      o_data,
    output logic                            o_valid,
    input  logic                            i_ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] o_level,
    output logic                            o_frame_err,
    output logic                            o_overrun,
    output logic                            o_parity_err,
    output logic [2:0]                      o_state
);

    localparam int DIV = uart_div(CLK_HZ, BAUD);
    localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
        PARITY_ODD < 0 || PARITY_ODD > 1 || DIV < 1) begin : g_param_check
        $error("uart_rx_fifo_ctrl: illegal parameter combination");
    end

    logic              rx_meta;
    logic              rx_s;
    logic [TW-1:0]     tick_cnt;
    logic              tick;
    logic [2:0]        state;
    logic [3:0]        os_cnt;
    logic [2:0]        bit_cnt;
    logic [7:0]        shreg;
    logic              mid_sample;
    logic              stop_sample;
    logic              push_req;
    logic              frame_hit;
    logic              par_hit;
    logic              fifo_empty;
    logic              fifo_full;
    logic              pop;

    always_ff @(posedge i_clk_50mhz or negedge i_reset_n) begin
        if (!i_reset_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= i_rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge i_clk_50mhz or negedge i_reset_n) begin
        if (!i_reset_n) begin
            tick_cnt <= '0;
        end else if (state == ST_IDLE || tick_cnt == TW'(DIV - 1)) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + TW'(1);
        end
    end

    assign tick = (state != ST_IDLE) && (tick_cnt == TW'(DIV - 1));

    // START samples at half a bit; every later state samples one full bit after the previous sample.
    assign mid_sample  = tick && (os_cnt == ((state == ST_START) ? 4'(OVERSAMPLE / 2 - 1)
                                                                  : 4'(OVERSAMPLE - 1)));
    assign stop_sample = (state == ST_STOP) && mid_sample;
    assign pop         = !fifo_empty && i_ready;

`ifdef UART_RX_PARITY_EN
    logic par_bad;

    assign push_req  = stop_sample && rx_s && !par_bad;
    assign frame_hit = stop_sample && !rx_s && !par_bad;
    assign par_hit   = stop_sample && par_bad;
`else
    assign push_req  = stop_sample && rx_s;
    assign frame_hit = stop_sample && !rx_s;
    assign par_hit   = 1'b0;
`endif

    always_ff @(posedge i_clk_50mhz or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state   <= ST_IDLE;
            os_cnt  <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
`ifdef UART_RX_PARITY_EN
            par_bad <= 1'b0;
`endif
        end else begin
            if (state != ST_IDLE && tick) begin
                os_cnt <= mid_sample ? 4'd0 : os_cnt + 4'd1;
            end
            case (state)
                ST_IDLE: begin
                    os_cnt  <= '0;
`ifdef UART_RX_PARITY_EN
                    par_bad <= 1'b0;
`endif
                    if (!rx_s) begin
                        state <= ST_START;
                    end
                end
                ST_START: begin
                    if (mid_sample) begin
                        bit_cnt <= '0;
                        state   <= rx_s ? ST_IDLE : ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (mid_sample) begin
                        shreg   <= {rx_s, shreg[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                            state <= ST_PARITY;
`else
                            state <= ST_STOP;
`endif
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (mid_sample) begin
                        par_bad <= ((^shreg) ^ rx_s) != PARITY_ODD[0];
                        state   <= ST_STOP;
                    end
                end
`endif
                ST_STOP: begin
                    if (mid_sample) begin
                        state <= rx_s ? ST_IDLE : ST_WAIT_IDLE;
                    end
                end
                ST_WAIT_IDLE: begin
                    if (rx_s) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk_50mhz or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_frame_err  <= 1'b0;
            o_overrun    <= 1'b0;
            o_parity_err <= 1'b0;
        end else begin
            o_frame_err  <= frame_hit;
            o_overrun    <= push_req && fifo_full && !pop;
            o_parity_err <= par_hit;
        end
    end

    uart_rx_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk       (i_clk_50mhz),
        .rst_n     (i_reset_n),
        .push      (push_req),
        .push_data (shreg),
        .pop       (pop),
        .head      (o_data),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .level     (o_level)
    );

    assign o_valid = !fifo_empty;
    assign o_state = state;

endmodule

// File: tb/tb_uart_rx_fifo_ctrl.sv
// Directed bench for uart_rx_fifo_ctrl at 50 MHz / 115200 baud (432 clocks per bit).
module tb_uart_rx_fifo_ctrl;

    localparam int BIT_CLKS = 432;
    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_START     = 3'd1;
    localparam logic [2:0] S_STOP      = 3'd4;
    localparam logic [2:0] S_WAIT_IDLE = 3'd5;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic       ready = 1'b0;
    logic [7:0] data;
    logic       valid;
    logic [3:0] level;
    logic       frame_err;
    logic       overrun;
    logic       parity_err;
    logic [2:0] state;

    int n_checks = 0;
    int n_fail   = 0;
    int fe_cnt   = 0;
    int ov_cnt   = 0;
    int pe_cnt   = 0;
    logic [7:0] exp_q[$];

    always #10 clk = ~clk;

    uart_rx_fifo_ctrl dut (
        .i_clk_50mhz  (clk),
        .i_reset_n    (rst_n),
        .i_rx         (rx),
        .o_data       (data),
        .o_valid      (valid),
        .i_ready      (ready),
        .o_level      (level),
        .o_frame_err  (frame_err),
        .o_overrun    (overrun),
        .o_parity_err (parity_err),
        .o_state      (state)
    );

    always @(negedge clk) begin
        if (rst_n) begin
            if (frame_err)  fe_cnt++;
            if (overrun)    ov_cnt++;
            if (parity_err) pe_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        repeat (BIT_CLKS) @(posedge clk);
    endtask

    // Leaves the stop-bit level on the line.
    task automatic send_frame(input logic [7:0] d, input logic stop_v,
                              input logic with_par, input logic par_v);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        if (with_par) send_bit(par_v);
        send_bit(stop_v);
    endtask

    task automatic pop_check(input string tag, input logic [7:0] exp_v);
        @(negedge clk);
        check({tag, "_valid"}, 32'(valid), 32'd1);
        check({tag, "_data"}, 32'(data), 32'(exp_v));
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
    endtask

    initial begin
        int lat;
        int cnt;
        int fe0;
        int ov0;

        // Reset with the line toggling.
        repeat (4) begin
            @(negedge clk);
            rx = ~rx;
            check("rst_valid", 32'(valid), 32'd0);
            check("rst_errs", {29'd0, frame_err, overrun, parity_err}, 32'd0);
        end
        check("rst_level", 32'(level), 32'd0);
        check("rst_data", 32'(data), 32'd0);
        check("rst_state", 32'(state), 32'(S_IDLE));
        rx = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("idle_state", 32'(state), 32'(S_IDLE));

        // 0xA5: push lands at mid stop bit, about 9.5 bits after the start edge.
        lat = 0;
        fork
            send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
            begin
                while (!valid && lat < 5000) begin
                    @(negedge clk);
                    lat++;
                end
            end
        join
        check("a5_latency_window", 32'(lat >= 9 * BIT_CLKS && lat <= 10 * BIT_CLKS), 32'd1);
        check("a5_level", 32'(level), 32'd1);
        check("a5_frame_err", 32'(fe_cnt), 32'd0);
        pop_check("a5", 8'hA5);
        check("a5_popped_valid", 32'(valid), 32'd0);
        check("a5_popped_level", 32'(level), 32'd0);

        // Reset in the middle of a frame discards it.
        rx = 1'b0;
        repeat (600) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_state", 32'(state), 32'(S_IDLE));
        rx = 1'b1;
        rst_n = 1'b1;
        repeat (4500) @(negedge clk);
        check("midrst_valid", 32'(valid), 32'd0);
        check("midrst_state_after", 32'(state), 32'(S_IDLE));

        // Low glitch of three ticks is rejected at the half-bit start check.
        rx = 1'b0;
        repeat (40) @(negedge clk);
        check("glitch_in_start", 32'(state), 32'(S_START));
        repeat (41) @(negedge clk);
        rx = 1'b1;
        repeat (300) @(negedge clk);
        check("glitch_state", 32'(state), 32'(S_IDLE));
        check("glitch_level", 32'(level), 32'd0);
        check("glitch_frame_err", 32'(fe_cnt), 32'd0);

        // Framing error followed by a stuck-low line, then a clean frame.
        fe0 = fe_cnt;
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
        repeat (5 * BIT_CLKS) @(negedge clk);
        check("break_state", 32'(state), 32'(S_WAIT_IDLE));
        check("break_frame_err", 32'(fe_cnt - fe0), 32'd1);
        check("break_level", 32'(level), 32'd0);
        rx = 1'b1;
        repeat (BIT_CLKS) @(negedge clk);
        check("break_recover", 32'(state), 32'(S_IDLE));
        send_frame(8'h55, 1'b1, 1'b0, 1'b0);
        repeat (20) @(negedge clk);
        check("after_break_level", 32'(level), 32'd1);
        pop_check("after_break", 8'h55);
        check("after_break_frame_err", 32'(fe_cnt - fe0), 32'd1);

        // Fill to capacity; ninth byte overruns.
        ready = 1'b0;
        ov0 = ov_cnt;
        for (int i = 0; i < 9; i++) send_frame(8'(i), 1'b1, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        check("full_level", 32'(level), 32'd8);
        check("full_overrun", 32'(ov_cnt - ov0), 32'd1);
        check("full_head", 32'(data), 32'h00);

        // Push and pop on the same edge while full: pop lands on the 16th tick after STOP entry.
        cnt = 0;
        fork
            send_frame(8'h09, 1'b1, 1'b0, 1'b0);
            begin
                while (state != S_STOP && cnt < 6000) begin
                    @(negedge clk);
                    cnt++;
                end
                check("stop_wait_in_budget", 32'(cnt < 6000), 32'd1);
                repeat (BIT_CLKS - 1) @(negedge clk);
                check("pp_level_before", 32'(level), 32'd8);
                ready = 1'b1;
                @(negedge clk);
                ready = 1'b0;
                check("pp_level_after", 32'(level), 32'd8);
                check("pp_state", 32'(state), 32'(S_IDLE));
                check("pp_head", 32'(data), 32'h01);
            end
        join
        check("pp_overrun", 32'(ov_cnt - ov0), 32'd1);

        for (int i = 1; i < 8; i++) exp_q.push_back(8'(i));
        exp_q.push_back(8'h09);
        while (exp_q.size() > 0) pop_check("drain", exp_q.pop_front());
        check("drain_valid", 32'(valid), 32'd0);
        check("drain_level", 32'(level), 32'd0);
        check("drain_hold_data", 32'(data), 32'h09);
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        check("empty_pop_level", 32'(level), 32'd0);
        check("empty_pop_valid", 32'(valid), 32'd0);

`ifdef UART_RX_PARITY_EN
        // Even parity: 0x07 has three ones, so parity bit 1 is correct.
        fe0 = fe_cnt;
        send_frame(8'h07, 1'b1, 1'b1, 1'b1);
        repeat (10) @(negedge clk);
        check("par_ok_level", 32'(level), 32'd1);
        check("par_ok_pe", 32'(pe_cnt), 32'd0);
        pop_check("par_ok", 8'h07);
        send_frame(8'h07, 1'b1, 1'b1, 1'b0);
        repeat (10) @(negedge clk);
        check("par_bad_pe", 32'(pe_cnt), 32'd1);
        check("par_bad_level", 32'(level), 32'd0);
        check("par_bad_fe", 32'(fe_cnt - fe0), 32'd0);
`else
        check("no_parity_pulses", 32'(pe_cnt), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
